// File: rtl/vga_frame_reader.sv
// VGA raster timing plus RGB444 frame-buffer streaming from a 1-cycle-latency synchronous RAM.
// rd_addr/rd_en describe the current counter position; video outputs trail it by exactly two clocks.
module vga_frame_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        disp_en,
    output logic [18:0] rd_addr,
    output logic        rd_en,
    input  logic [11:0] rd_data,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_IMG    = HW'(IMG_W);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_IMG    = VW'(IMG_H);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [HW-1:0] r_h_cnt, w_h_next;
    logic [VW-1:0] r_v_cnt, w_v_next;
    logic [18:0]   r_addr, w_addr_next;
    logic          r_rd_en;
    logic          w_in_img, w_in_img_next;
    logic          w_de_pos, w_hs_pos, w_vs_pos, w_fs_pos;

    logic          r_img_d1, r_en_d1, r_de_d1, r_hs_d1, r_vs_d1, r_fs_d1;
    logic          r_de, r_hs, r_vs, r_fs;
    logic [11:0]   r_rgb;

    function automatic logic f_in_img(input logic [HW-1:0] h, input logic [VW-1:0] v);
        return (h < H_IMG) && (v < V_IMG) && (h < H_ACT) && (v < V_ACT);
    endfunction

    always_comb begin
        w_h_next = r_h_cnt + HW'(1);
        w_v_next = r_v_cnt;
        if (r_h_cnt == H_LAST) begin
            w_h_next = '0;
            w_v_next = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
        end
    end

    assign w_in_img      = f_in_img(r_h_cnt, r_v_cnt);
    assign w_in_img_next = f_in_img(w_h_next, w_v_next);
    assign w_de_pos      = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_hs_pos      = (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
    assign w_vs_pos      = (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);
    assign w_fs_pos      = (r_h_cnt == '0) && (r_v_cnt == '0);

    // The address register always holds the last in-image address, so a new line simply continues +1.
    always_comb begin
        w_addr_next = r_addr;
        if ((w_h_next == '0) && (w_v_next == '0)) begin
            w_addr_next = '0;
        end else if (w_in_img_next) begin
            w_addr_next = r_addr + 19'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
            r_addr  <= '0;
            r_rd_en <= 1'b0;
        end else begin
            r_h_cnt <= w_h_next;
            r_v_cnt <= w_v_next;
            r_addr  <= w_addr_next;
            r_rd_en <= w_in_img_next;
        end
    end

    // Stage 1 waits alongside the RAM read; stage 2 registers everything together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_img_d1 <= 1'b0;
            r_en_d1  <= 1'b0;
            r_de_d1  <= 1'b0;
            r_hs_d1  <= 1'b1;
            r_vs_d1  <= 1'b1;
            r_fs_d1  <= 1'b0;
            r_de     <= 1'b0;
            r_hs     <= 1'b1;
            r_vs     <= 1'b1;
            r_fs     <= 1'b0;
            r_rgb    <= 12'h000;
        end else begin
            r_img_d1 <= w_in_img;
            r_en_d1  <= disp_en;
            r_de_d1  <= w_de_pos;
            r_hs_d1  <= ~w_hs_pos;
            r_vs_d1  <= ~w_vs_pos;
            r_fs_d1  <= w_fs_pos;
            r_de     <= r_de_d1;
            r_hs     <= r_hs_d1;
            r_vs     <= r_vs_d1;
            r_fs     <= r_fs_d1;
            r_rgb    <= (r_img_d1 && r_en_d1) ? rd_data : 12'h000;
        end
    end

    assign rd_addr     = r_addr;
    assign rd_en       = r_rd_en;
    assign hsync       = r_hs;
    assign vsync       = r_vs;
    assign de          = r_de;
    assign frame_start = r_fs;
    assign vga_r       = r_rgb[11:8];
    assign vga_g       = r_rgb[7:4];
    assign vga_b       = r_rgb[3:0];
endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader on a shrunken raster: one full-image instance and one 8x6 window instance.
`timescale 1ns/1ps
module tb_vga_frame_reader;
    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VA = 12, VF = 1, VS = 2, VB = 2;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam int AW = 16, AH = 12;
    localparam int BW = 8,  BH = 6;

    typedef struct {
        int          h;
        int          v;
        int          fr;
        int          tidx;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [11:0] rgb;
    } exp_t;

    typedef struct {
        int          h;
        int          v;
        logic        ovr;
        logic [11:0] data;
        logic [3:0]  r;
        logic [3:0]  g;
        logic [3:0]  b;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        disp_en = 1'b1;
    logic        b_disp_en = 1'b1;
    logic        tbl_on = 1'b0;
    logic [18:0] a_addr, b_addr;
    logic        a_rd_en, b_rd_en;
    logic [11:0] a_data = 12'h000, b_data = 12'h000;
    logic        a_hs, a_vs, a_de, a_fs, b_hs, b_vs, b_de, b_fs;
    logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b;

    exp_t q_a[$];
    exp_t q_b[$];
    vec_t tbl[6];
    int   checks = 0;
    int   errors = 0;

    vga_frame_reader #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                       .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                       .IMG_W(AW), .IMG_H(AH)) u_a (
        .clk(clk), .rst(rst), .disp_en(disp_en), .rd_addr(a_addr), .rd_en(a_rd_en),
        .rd_data(a_data), .hsync(a_hs), .vsync(a_vs), .de(a_de), .vga_r(a_r),
        .vga_g(a_g), .vga_b(a_b), .frame_start(a_fs));

    vga_frame_reader #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                       .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                       .IMG_W(BW), .IMG_H(BH)) u_b (
        .clk(clk), .rst(rst), .disp_en(b_disp_en), .rd_addr(b_addr), .rd_en(b_rd_en),
        .rd_data(b_data), .hsync(b_hs), .vsync(b_vs), .de(b_de), .vga_r(b_r),
        .vga_g(b_g), .vga_b(b_b), .frame_start(b_fs));

    always #5 clk = ~clk;

    // Frame-buffer models: data = address LSBs, with table overrides for instance A.
    function automatic logic [11:0] ram_a(input logic [18:0] ad);
        logic [11:0] d;
        d = ad[11:0];
        if (tbl_on)
            for (int i = 0; i < 6; i++)
                if (tbl[i].ovr && (32'(ad) == 32'(tbl[i].v * AW + tbl[i].h))) d = tbl[i].data;
        return d;
    endfunction

    always @(posedge clk) begin
        a_data <= ram_a(a_addr);
        b_data <= b_addr[11:0];
    end

    function automatic logic in_img(input int h, input int v, input int iw, input int ih);
        return (h < iw) && (v < ih) && (h < HA) && (v < VA);
    endfunction

    function automatic logic [18:0] exp_addr(input int h, input int v, input int iw, input int ih);
        if (h < iw && v < ih) return 19'(v * iw + h);
        else if (v < ih)      return 19'(v * iw + iw - 1);
        else                  return 19'(iw * ih - 1);
    endfunction

    function automatic exp_t mk(input int h, input int v, input int fr, input int iw, input int ih,
                                input logic en, input logic use_tbl);
        exp_t        e;
        logic [18:0] ad;
        ad     = exp_addr(h, v, iw, ih);
        e.h    = h;
        e.v    = v;
        e.fr   = fr;
        e.tidx = -1;
        if (use_tbl && fr == 2)
            for (int i = 0; i < 6; i++)
                if (tbl[i].h == h && tbl[i].v == v) e.tidx = i;
        e.hs  = !(h >= HA + HF && h < HA + HF + HS);
        e.vs  = !(v >= VA + VF && v < VA + VF + VS);
        e.de  = (h < HA) && (v < VA);
        e.fs  = (h == 0) && (v == 0);
        e.rgb = (in_img(h, v, iw, ih) && en) ? (use_tbl ? ram_a(ad) : ad[11:0]) : 12'h000;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_a_sync"}, 32'({a_hs, a_vs}), 32'h3);
        chk({tag, "_a_de_fs_en"}, 32'({a_de, a_fs, a_rd_en}), 32'h0);
        chk({tag, "_a_rgb"}, 32'({a_r, a_g, a_b}), 32'h0);
        chk({tag, "_a_addr"}, 32'(a_addr), 32'h0);
        chk({tag, "_b_state"}, 32'({b_hs, b_vs, b_de, b_fs, b_rd_en, b_r, b_g, b_b}), 32'(17'h18000));
        chk({tag, "_b_addr"}, 32'(b_addr), 32'h0);
    endtask

    task automatic pop_check();
        exp_t ea, eb;
        chk("sb_queue_nonempty", 32'(q_a.size() > 0 && q_b.size() > 0), 32'h1);
        if (q_a.size() == 0 || q_b.size() == 0) return;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        chk($sformatf("a_out(%0d,%0d)", ea.h, ea.v), 32'({a_hs, a_vs, a_de, a_fs, a_r, a_g, a_b}),
            32'({ea.hs, ea.vs, ea.de, ea.fs, ea.rgb}));
        chk($sformatf("b_out(%0d,%0d)", eb.h, eb.v), 32'({b_hs, b_vs, b_de, b_fs, b_r, b_g, b_b}),
            32'({eb.hs, eb.vs, eb.de, eb.fs, eb.rgb}));
        if (ea.tidx >= 0)
            chk($sformatf("tbl%0d_rgb", ea.tidx), 32'({a_r, a_g, a_b}),
                32'({tbl[ea.tidx].r, tbl[ea.tidx].g, tbl[ea.tidx].b}));
        if (ea.fr == 3 && ea.v == 3 && ea.h == 5) chk("dis_en_before", 32'({a_r, a_g, a_b}), 32'h035);
        if (ea.fr == 3 && ea.v == 3 && ea.h == 6) chk("dis_en_after", 32'({a_de, a_r, a_g, a_b}), 32'h1000);
        if (eb.fr == 0 && eb.v == 2 && eb.h == 10) chk("win_h_black", 32'({b_de, b_r, b_g, b_b}), 32'h1000);
        if (eb.fr == 0 && eb.v == 7 && eb.h == 3)  chk("win_v_black", 32'({b_de, b_r, b_g, b_b}), 32'h1000);
    endtask

    task automatic run(input int n, input int rst_at);
        int   h, v, fr;
        int   hs_low, vs_low, de_hi, fs_cnt;
        exp_t rr;
        hs_low = 0; vs_low = 0; de_hi = 0; fs_cnt = 0;
        rr = '{h:-1, v:-1, fr:-1, tidx:-1, hs:1'b1, vs:1'b1, de:1'b0, fs:1'b0, rgb:12'h000};
        q_a.delete();
        q_b.delete();
        repeat (2) begin
            q_a.push_back(rr);
            q_b.push_back(rr);
        end
        rst = 1'b1;
        for (int p = 0; p < n; p++) begin
            h  = p % HT;
            v  = (p / HT) % VT;
            fr = p / FR;
            pop_check();
            if (p >= 2 && p < 2 + 2 * FR) begin
                if (!a_hs) hs_low++;
                if (!a_vs) vs_low++;
                if (a_de)  de_hi++;
                if (a_fs)  fs_cnt++;
            end
            if (p == 2 + 2 * FR) begin
                chk("hsync_low_2frames", 32'(hs_low), 32'(2 * VT * HS));
                chk("vsync_low_2frames", 32'(vs_low), 32'(2 * VS * HT));
                chk("de_high_2frames", 32'(de_hi), 32'(2 * HA * VA));
                chk("frame_start_2frames", 32'(fs_cnt), 32'h2);
            end
            if (p == 2) chk("first_frame_start", 32'(a_fs), 32'h1);
            chk($sformatf("a_addr(%0d,%0d)", h, v), 32'(a_addr), 32'(exp_addr(h, v, AW, AH)));
            chk($sformatf("b_addr(%0d,%0d)", h, v), 32'(b_addr), 32'(exp_addr(h, v, BW, BH)));
            if (p > 0) begin
                chk($sformatf("a_rd_en(%0d,%0d)", h, v), 32'(a_rd_en), 32'(in_img(h, v, AW, AH)));
                chk($sformatf("b_rd_en(%0d,%0d)", h, v), 32'(b_rd_en), 32'(in_img(h, v, BW, BH)));
            end
            if (h == 0 && v == 1) begin
                chk("a_line1_start", 32'(a_addr), 32'd16);
                chk("b_line1_start", 32'(b_addr), 32'd8);
            end
            if (h == 15 && v == 11) chk("a_last_pixel", 32'(a_addr), 32'd191);
            if (h == 20 && v == 9)  chk("b_addr_hold", 32'(b_addr), 32'd47);
            if (p == FR)            chk("a_addr_wrap", 32'(a_addr), 32'd0);
            if (p == rst_at) begin
                rst = 1'b0;
                #1;
                check_reset("mid");
                return;
            end
            disp_en = !(fr == 3 && v == 3 && h >= 6);
            tbl_on  = (fr == 2);
            q_a.push_back(mk(h, v, fr, AW, AH, disp_en, 1'b1));
            q_b.push_back(mk(h, v, fr, BW, BH, b_disp_en, 1'b0));
            @(negedge clk);
        end
    endtask

    initial begin
        tbl[0] = '{h:5,  v:0,  ovr:1'b0, data:12'h000, r:4'h0, g:4'h0, b:4'h5};
        tbl[1] = '{h:3,  v:1,  ovr:1'b1, data:12'hABC, r:4'hA, g:4'hB, b:4'hC};
        tbl[2] = '{h:10, v:4,  ovr:1'b1, data:12'h123, r:4'h1, g:4'h2, b:4'h3};
        tbl[3] = '{h:15, v:11, ovr:1'b1, data:12'hFFF, r:4'hF, g:4'hF, b:4'hF};
        tbl[4] = '{h:0,  v:7,  ovr:1'b1, data:12'h0F0, r:4'h0, g:4'hF, b:4'h0};
        tbl[5] = '{h:7,  v:2,  ovr:1'b1, data:12'h800, r:4'h8, g:4'h0, b:4'h0};
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_reset("por");
        end
        run(4 * FR + 4 * HT + 10, 4 * FR + 4 * HT + 9);
        repeat (3) begin
            @(negedge clk);
            check_reset("hold");
        end
        disp_en = 1'b1;
        run(FR + 10, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
